// File: rtl/elixirchip_es1_spu_op_flag_counter.sv
// rtl/elixirchip_es1_spu_op_flag_counter.sv - pipelined flag event counter with threshold hit and sticky overflow
// Overflow rule: define ELIXIRCHIP_ES1_SPU_OP_FLAG_COUNTER_SATURATE_EN to saturate, otherwise the count wraps.
module elixirchip_es1_spu_op_flag_counter #(
  parameter int    LATENCY    = 1,
  parameter int    COUNT_BITS = 8,
  parameter int    THRESHOLD  = 1,
  parameter string DEVICE     = "RTL",
  parameter string SIMULATION = "false",
  parameter string DEBUG      = "false"
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cke,
  input  logic                  s_flag,
  input  logic                  s_clear,
  input  logic                  s_valid,
  output logic [COUNT_BITS-1:0] m_count,
  output logic                  m_hit,
  output logic                  m_overflow
);

  // Each stage word is {cnt, hit, ovf}; stage_q[0] is the accumulator itself.
  localparam int W = COUNT_BITS + 2;
  localparam logic RESET_HIT = (THRESHOLD == 0);
  localparam logic [W-1:0] RESET_WORD = {{COUNT_BITS{1'b0}}, RESET_HIT, 1'b0};

  logic [W-1:0]          stage_q [LATENCY];
  logic [W-1:0]          stage1_d;
  logic [COUNT_BITS-1:0] cnt_cur;
  logic                  ovf_cur;
  logic [COUNT_BITS-1:0] base;
  logic [COUNT_BITS:0]   sum;
  logic                  carry;
  logic [COUNT_BITS-1:0] cnt_d;
  logic                  ovf_d;
  logic                  hit_d;

  assign cnt_cur = stage_q[0][W-1:2];
  assign ovf_cur = stage_q[0][0];

  always_comb begin
    base  = s_clear ? '0 : cnt_cur;
    sum   = {1'b0, base} + {{COUNT_BITS{1'b0}}, s_flag};
    carry = sum[COUNT_BITS];
`ifdef ELIXIRCHIP_ES1_SPU_OP_FLAG_COUNTER_SATURATE_EN
    cnt_d = carry ? '1 : sum[COUNT_BITS-1:0];
`else
    cnt_d = sum[COUNT_BITS-1:0];
`endif
    // A clear in the same sample drops the old sticky flag before any new carry.
    ovf_d = (ovf_cur & ~s_clear) | carry;
  end

  if (THRESHOLD == 0) begin : g_hit_always
    assign hit_d = 1'b1;
  end else begin : g_hit_cmp
    localparam logic [COUNT_BITS-1:0] THR = COUNT_BITS'(THRESHOLD);
    assign hit_d = (cnt_d >= THR);
  end

  assign stage1_d = {cnt_d, hit_d, ovf_d};

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        stage_q[i] <= RESET_WORD;
      end
    end else if (cke) begin
      if (s_valid) begin
        stage_q[0] <= stage1_d;
      end
      for (int i = 1; i < LATENCY; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign m_count    = stage_q[LATENCY-1][W-1:2];
  assign m_hit      = stage_q[LATENCY-1][1];
  assign m_overflow = stage_q[LATENCY-1][0];

endmodule

// File: tb/tb_elixirchip_es1_spu_op_flag_counter.sv
// tb/tb_elixirchip_es1_spu_op_flag_counter.sv - self-checking bench for the flag counter
// Honours ELIXIRCHIP_ES1_SPU_OP_FLAG_COUNTER_SATURATE_EN to pick the expected overflow rule.
module tb_elixirchip_es1_spu_op_flag_counter;

  localparam int LAT  = 2;
  localparam int CB   = 4;
  localparam int THR  = 3;
  localparam int MAXV = (1 << CB) - 1;
`ifdef ELIXIRCHIP_ES1_SPU_OP_FLAG_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cke = 1'b0;
  logic          s_flag = 1'b0;
  logic          s_clear = 1'b0;
  logic          s_valid = 1'b0;
  logic [CB-1:0] m_count;
  logic          m_hit;
  logic          m_overflow;

  int checks = 0;
  int errors = 0;

  // Reference model: integer count, sticky flag and a queue of visible results.
  int m_cnt = 0;
  int m_ovf = 0;
  int hist[$];

  always #5 clk = ~clk;

  elixirchip_es1_spu_op_flag_counter #(
    .LATENCY    (LAT),
    .COUNT_BITS (CB),
    .THRESHOLD  (THR),
    .DEVICE     ("RTL"),
    .SIMULATION ("true"),
    .DEBUG      ("false")
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cke        (cke),
    .s_flag     (s_flag),
    .s_clear    (s_clear),
    .s_valid    (s_valid),
    .m_count    (m_count),
    .m_hit      (m_hit),
    .m_overflow (m_overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int pack(input int c, input int o);
    return c * 4 + ((c >= THR) ? 2 : 0) + o;
  endfunction

  task automatic cycle(input logic r, input logic c, input logic v, input logic cl, input logic f);
    int base;
    int e;
    reset = r; cke = c; s_valid = v; s_clear = cl; s_flag = f;
    @(posedge clk);
    if (r) begin
      m_cnt = 0;
      m_ovf = 0;
      hist = {};
      repeat (LAT) hist.push_back(pack(0, 0));
    end else if (c) begin
      if (v) begin
        base = cl ? 0 : m_cnt;
        if (cl) m_ovf = 0;
        if (base + int'(f) > MAXV) begin
          m_ovf = 1;
          m_cnt = SAT ? MAXV : 0;
        end else begin
          m_cnt = base + int'(f);
        end
      end
      hist.push_back(pack(m_cnt, m_ovf));
      void'(hist.pop_front());
    end
    #1;
    e = hist[0];
    check("model_count", 32'(m_count), 32'(e / 4));
    check("model_hit", 32'(m_hit), 32'((e / 2) % 2));
    check("model_ovf", 32'(m_overflow), 32'(e % 2));
  endtask

  // One qualified sample, optionally preceded by random cke-low edges.
  task automatic sample(input logic v, input logic cl, input logic f);
    while ($urandom_range(0, 9) == 0)
      cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    cycle(1'b0, 1'b1, v, cl, f);
  endtask

  task automatic flush();
    sample(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    hist = {};
    repeat (LAT) hist.push_back(pack(0, 0));
    do_reset();
    check("rst_count", 32'(m_count), 0);
    check("rst_hit", 32'(m_hit), 0);
    check("rst_ovf", 32'(m_overflow), 0);

    // Counting 1..5, hit from 3 on.
    for (int i = 1; i <= 5; i++) begin
      sample(1'b1, 1'b0, 1'b1);
      flush();
      check("up_count", 32'(m_count), 32'(i));
      check("up_hit", 32'(m_hit), (i >= 3) ? 1 : 0);
      check("up_ovf", 32'(m_overflow), 0);
    end

    // Flags 1,0,1, invalid, then clear+flag.
    begin
      logic [2:0] v_t [5] = '{3'b101, 3'b100, 3'b101, 3'b001, 3'b111};
      int         c_t [5] = '{1, 1, 2, 2, 1};
      do_reset();
      for (int i = 0; i < 5; i++) begin
        sample(v_t[i][2], v_t[i][1], v_t[i][0]);
        flush();
        check("seq_count", 32'(m_count), 32'(c_t[i]));
        check("seq_hit", 32'(m_hit), 0);
      end
    end

    // Overflow at 2^CB-1, then clear.
    do_reset();
    repeat (MAXV + 1) sample(1'b1, 1'b0, 1'b1);
    flush();
    check("ovf_count", 32'(m_count), SAT ? 32'(MAXV) : 0);
    check("ovf_flag", 32'(m_overflow), 1);
    sample(1'b1, 1'b1, 1'b0);
    flush();
    check("clr_count", 32'(m_count), 0);
    check("clr_ovf", 32'(m_overflow), 0);

    // cke low freezes everything.
    do_reset();
    repeat (3) sample(1'b1, 1'b0, 1'b1);
    flush();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, ~s_flag);
      check("hold_count", 32'(m_count), 3);
      check("hold_hit", 32'(m_hit), 1);
    end
    sample(1'b1, 1'b0, 1'b1);
    flush();
    check("resume_count", 32'(m_count), 4);

    // Reset mid-run at count 7.
    do_reset();
    repeat (7) sample(1'b1, 1'b0, 1'b1);
    flush();
    check("pre_rst_count", 32'(m_count), 7);
    cycle(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b1);
    check("mid_rst_count", 32'(m_count), 0);
    check("mid_rst_hit", 32'(m_hit), 0);
    check("mid_rst_ovf", 32'(m_overflow), 0);
    sample(1'b1, 1'b0, 1'b1);
    flush();
    check("restart_count", 32'(m_count), 1);

    // Random traffic against the model.
    for (int i = 0; i < 1000; i++) begin
      cycle(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 9) != 0),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
            1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
